// File: rtl/regfile_mp.sv
// Multi-port register file with optional hard-wired zero register, write-to-read
// bypass and a selectable combinational or registered read stage.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int HAS_ZERO = 1,
  parameter int BYPASS   = 1,
  parameter int RD_LAT   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wr_ok;
  logic              fwd_ok;

  // The zero register never stores anything, so its slot stays at reset value.
  assign wr_ok  = wr_en && !clr && !((HAS_ZERO != 0) && (wr_addr == ZERO_ADDR));
  assign fwd_ok = (BYPASS != 0) && wr_en && !clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_ok) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Zero register beats the bypass; the bypass beats stored contents.
      always_comb begin
        val = mem_reg[addr];
        if ((HAS_ZERO != 0) && (addr == ZERO_ADDR)) begin
          val = '0;
        end else if (fwd_ok && (wr_addr == addr)) begin
          val = wr_data;
        end
      end

      if (RD_LAT == 0) begin : g_comb
        // Outputs are forced low while reset is held, even for a forwarded write.
        assign rd_data[gi*DATA_W +: DATA_W] = reset_n ? val : '0;
        assign rd_valid[gi]                 = rd_en[gi] & reset_n;
      end else begin : g_reg
        logic [DATA_W-1:0] data_reg;
        logic              valid_reg;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
          end else begin
            valid_reg <= rd_en[gi];
            if (rd_en[gi]) data_reg <= val;
          end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
        assign rd_valid[gi]                 = valid_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four parameterisations driven from one write/clear/reset
// stream, checked against table constants and a behavioural register model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clr, wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en2;
  logic [9:0]  rd_addr2;
  logic [3:0]  rd_en4;
  logic [19:0] rd_addr4;

  logic [127:0] def_data, nb_data, lat_data;
  logic [1:0]   def_valid, nb_valid, lat_valid;
  logic [255:0] mp_data;
  logic [3:0]   mp_valid;

  regfile_mp u_def (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(def_data), .rd_valid(def_valid));

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(nb_data), .rd_valid(nb_valid));

  regfile_mp #(.RD_LAT(1)) u_lat (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(lat_data), .rd_valid(lat_valid));

  regfile_mp #(.NUM_RD(4)) u_mp (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(mp_data), .rd_valid(mp_valid));

  // Reference model: register contents plus the registered-read stage state.
  logic [63:0] mem_m [32];
  logic [63:0] hold_m [2];
  logic [1:0]  val_m;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        cl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] n0;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] readval(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'h0;
    if (byp && wr_en && !clr && wr_addr == a) return wr_data;
    return mem_m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 64'h0;
    hold_m[0] = 64'h0;
    hold_m[1] = 64'h0;
    val_m = 2'b00;
  endtask

  // Advance to just after the next rising edge and apply that edge to the model.
  task automatic edge_update();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (rd_en2[p]) hold_m[p] = readval(rd_addr2[p*5 +: 5], 1'b1);
      val_m[p] = rd_en2[p];
    end
    if (clr) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 64'h0;
    end else if (wr_en && wr_addr != 5'd31) begin
      mem_m[wr_addr] = wr_data;
    end
  endtask

  task automatic check_comb();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("def_data%0d", p), def_data[p*64 +: 64], readval(rd_addr2[p*5 +: 5], 1'b1));
      chk($sformatf("nb_data%0d", p), nb_data[p*64 +: 64], readval(rd_addr2[p*5 +: 5], 1'b0));
    end
    chk("def_valid", 64'(def_valid), 64'(rd_en2));
    for (int p = 0; p < 4; p++)
      chk($sformatf("mp_data%0d", p), mp_data[p*64 +: 64], readval(rd_addr4[p*5 +: 5], 1'b1));
    chk("mp_valid", 64'(mp_valid), 64'(rd_en4));
  endtask

  task automatic check_lat();
    chk("lat_data0", lat_data[63:0], hold_m[0]);
    chk("lat_data1", lat_data[127:64], hold_m[1]);
    chk("lat_valid", 64'(lat_valid), 64'(val_m));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_def_d0"}, def_data[63:0], 64'h0);
    chk({tag, "_def_d1"}, def_data[127:64], 64'h0);
    chk({tag, "_def_v"}, 64'(def_valid), 64'h0);
    chk({tag, "_lat_d0"}, lat_data[63:0], 64'h0);
    chk({tag, "_lat_d1"}, lat_data[127:64], 64'h0);
    chk({tag, "_lat_v"}, 64'(lat_valid), 64'h0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [4:0]  a;

    tbl[0] = '{1'b1, 5'd3,  64'h11,     1'b0, 5'd3,  5'd4, 64'h11,   64'h0,    64'h0};
    tbl[1] = '{1'b1, 5'd3,  64'h22,     1'b0, 5'd3,  5'd3, 64'h22,   64'h22,   64'h11};
    tbl[2] = '{1'b0, 5'd0,  64'h0,      1'b0, 5'd3,  5'd31, 64'h22,  64'h0,    64'h22};
    tbl[3] = '{1'b1, 5'd31, 64'hFFFF,   1'b0, 5'd31, 5'd3, 64'h0,    64'h22,   64'h0};
    tbl[4] = '{1'b1, 5'd6,  64'h66,     1'b1, 5'd3,  5'd6, 64'h22,   64'h0,    64'h22};
    tbl[5] = '{1'b0, 5'd0,  64'h0,      1'b0, 5'd3,  5'd6, 64'h0,    64'h0,    64'h0};
    tbl[6] = '{1'b1, 5'd0,  64'h1234,   1'b0, 5'd0,  5'd0, 64'h1234, 64'h1234, 64'h0};
    tbl[7] = '{1'b0, 5'd0,  64'h0,      1'b0, 5'd0,  5'd5, 64'h1234, 64'h0,    64'h1234};

    reset_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en2 = 2'b11; rd_addr2 = '0; rd_en4 = '0; rd_addr4 = '0;
    model_reset();
    #1;
    check_all_zero("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table vectors: bypass, zero register, clear-vs-write, no-bypass variant.
    for (int v = 0; v < 8; v++) begin
      wr_en = tbl[v].we; wr_addr = tbl[v].wa; wr_data = tbl[v].wd; clr = tbl[v].cl;
      rd_en2 = 2'b11; rd_addr2 = {tbl[v].ra1, tbl[v].ra0};
      @(negedge clk);
      $display("vec %0d: we=%0d wa=%0d clr=%0d ra=%0d/%0d", v, tbl[v].we, tbl[v].wa,
               tbl[v].cl, tbl[v].ra0, tbl[v].ra1);
      chk($sformatf("tbl%0d_def0", v), def_data[63:0], tbl[v].e0);
      chk($sformatf("tbl%0d_def1", v), def_data[127:64], tbl[v].e1);
      chk($sformatf("tbl%0d_nb0", v), nb_data[63:0], tbl[v].n0);
      edge_update();
      check_lat();
    end

    // Asynchronous reset wipes storage and outputs without an edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD; clr = 1'b0;
    rd_en2 = 2'b11; rd_addr2 = {5'd5, 5'd5};
    edge_update();
    wr_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_x5", def_data[63:0], 64'hDEAD);
    #1;
    reset_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    check_all_zero("rst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_x5", def_data[63:0], 64'h0);
    edge_update();

    // Clear beats a simultaneous write.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF;
    edge_update();
    wr_addr = 5'd6; wr_data = 64'h66; clr = 1'b1;
    edge_update();
    clr = 1'b0; wr_en = 1'b0; rd_addr2 = {5'd6, 5'd5};
    @(negedge clk);
    $display("clear with write to X6");
    chk("clr_x5", def_data[63:0], 64'h0);
    chk("clr_x6", def_data[127:64], 64'h0);
    edge_update();

    // Write every register, then read every address on both ports.
    rd_en2 = 2'b00;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      edge_update();
    end
    wr_en = 1'b0; rd_en2 = 2'b11;
    for (int i = 0; i < 32; i++) begin
      rd_addr2 = {5'(i), 5'(i)};
      exp = (i == 31) ? 64'h0 : (64'hA5A5_0000_0000_0000 | 64'(i));
      @(negedge clk);
      $display("read all: X%0d", i);
      chk($sformatf("all_def0_x%0d", i), def_data[63:0], exp);
      chk($sformatf("all_def1_x%0d", i), def_data[127:64], exp);
      chk($sformatf("all_nb0_x%0d", i), nb_data[63:0], exp);
      edge_update();
      chk($sformatf("all_lat1_x%0d", i), lat_data[127:64], exp);
    end

    // Registered read on port 1: valid after the edge, then held data.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77; rd_en2 = 2'b00;
    edge_update();
    wr_en = 1'b0; rd_en2 = 2'b10; rd_addr2 = {5'd7, 5'd0};
    edge_update();
    $display("registered read X7 on port 1");
    chk("lat_n_valid1", 64'(lat_valid[1]), 64'h1);
    chk("lat_n_data1", lat_data[127:64], 64'h77);
    rd_en2 = 2'b00;
    edge_update();
    chk("lat_n1_valid1", 64'(lat_valid[1]), 64'h0);
    chk("lat_n1_data1", lat_data[127:64], 64'h77);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h99; rd_en2 = 2'b10;
    edge_update();
    $display("same-edge write/read X7");
    chk("lat_byp_data1", lat_data[127:64], 64'h99);

    // Reset between registered reads drops data and valid immediately.
    wr_en = 1'b0; rd_en2 = 2'b01; rd_addr2 = {5'd0, 5'd7};
    edge_update();
    chk("midrd_data0", lat_data[63:0], 64'h99);
    chk("midrd_valid0", 64'(lat_valid[0]), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    $display("reset during registered read");
    chk("midrd_rst_d0", lat_data[63:0], 64'h0);
    chk("midrd_rst_d1", lat_data[127:64], 64'h0);
    chk("midrd_rst_v", 64'(lat_valid), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Random traffic against the model, all four instances.
    for (int c = 0; c < 1000; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      clr     = ($urandom_range(0, 49) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      rd_en2  = 2'($urandom_range(0, 3));
      rd_en4  = 4'($urandom_range(0, 15));
      rd_addr2 = 10'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = 5'($urandom_range(0, 31));
        rd_addr4 = {a, a, a, a};
      end else begin
        rd_addr4 = 20'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        rd_addr4[4:0] = wr_addr;
        rd_addr2[4:0] = wr_addr;
      end
      @(negedge clk);
      check_comb();
      edge_update();
      check_lat();
    end
    $display("random phase: 1000 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
